game_ctrl: RTL
==============

// Module: game_ctrl
// PURPOSE
//  Turn-sequencing controller for the two-player digit game shown by the game page renderer.
//  Owns the board state and feeds the renderer: status, cursor, selection, prediction, player, result.
//  Inputs are single-cycle button pulses, already debounced and synchronised to vga_clk.
//  Move rule: current player picks an own digit a, then an opponent digit b; a <= (a+b) mod 10.
//  A player whose digits are all zero wins.
// PARAMETERS
//  N_MAX       5  max digits per player (status = 2*N_MAX*4 bits)
//  INIT_DIGIT  1  value loaded into every active digit at game start (1..9)
// PORTS
//  vga_clk       in   1   clock
//  vga_rst       in   1   asynchronous, active-high reset
//  num_cfg       in   3   digits per player requested at start (clamped to 1..N_MAX)
//  start         in   1   pulse: begin a new game (accepted in IDLE and END only)
//  btn_left      in   1   pulse: cursor to previous index in active row
//  btn_right     in   1   pulse: cursor to next index in active row
//  btn_ok        in   1   pulse: confirm cursor position
//  btn_cancel    in   1   pulse: drop the source selection
//  total_number  out  32  digits per player, latched at start
//  cur_player    out  1   0 = top row (indices 0..4) to move; 1 = bottom row (5..9)
//  status        out  40  digit i at [4i+3:4i]; top row i = 0..4, bottom row at base bit 20
//  predict       out  4   (src+cursor digit) mod 10 while selecting, else 0
//  selecting     out  1   source digit chosen, awaiting target
//  cur_select    out  32  cursor object index * 4
//  selected      out  32  source object index * 4
//  game_end      out  2   0 = playing, 1 = top player won, 2 = bottom player won
// BEHAVIOUR
//  Reset: state=IDLE; status=0; every other output is 0; total_number=0.
//  States: IDLE -> (start) INIT -> PICK_SRC <-> PICK_TGT -> APPLY -> CHECK -> PICK_SRC | END.
//  END -> (start) INIT.
//  INIT (1 cycle):
//   - total_number <= clamp(num_cfg); active digits <= INIT_DIGIT; unused digits <= 0.
//   - cur_player <= 0; cursor <= index 0; game_end <= 0.
//  Object index mapping: top row i maps to index i; bottom row i maps to index 5+i.
//  Cursor confinement: own row in PICK_SRC, opponent row in PICK_TGT.
//   - Moves across positions 0..total_number-1 of that row and wraps at both ends.
//  Button priority when pulses coincide: cancel > ok > left > right. One action per cycle.
//  PICK_SRC:
//   - ok on a nonzero digit: selected <= cursor; selecting <= 1; cursor <= opponent row position 0.
//   - ok on a zero digit is ignored. cancel has no effect.
//  PICK_TGT:
//   - ok on a nonzero digit goes to APPLY; ok on a zero digit is ignored.
//   - cancel: selecting <= 0; cursor <= selected; back to PICK_SRC.
//  predict is registered: it reflects the cursor one cycle after the cursor moves.
//  APPLY (1 cycle): src digit <= (src+tgt) mod 10, computed as a 5-bit sum minus 10 if >= 10.
//   - selecting <= 0.
//  CHECK (1 cycle), evaluated on the updated status:
//   - Mover's active digits all zero: game_end <= 1 + cur_player; go to END.
//   - Otherwise: cur_player toggles; cursor <= new player's row position 0; go to PICK_SRC.
//  END: board frozen; all buttons ignored; only start is accepted.
//  start outside IDLE/END is ignored. Buttons in IDLE/INIT/APPLY/CHECK are dropped, not queued.
//  Reset mid-move returns to IDLE asynchronously; no partial APPLY survives.
// CONFIGURATION
//  RANDOM_INIT_EN defined:
//   - A free-running 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) runs every cycle.
//   - INIT loads each active digit as 1 + (4-bit LFSR slice mod 9), giving 1..9.
//  RANDOM_INIT_EN undefined: INIT_DIGIT is used for every active digit and no LFSR is built.
// STRUCTURE
//  Shared header game_defs.vh holds:
//   - state encodings (IDLE, INIT, PICK_SRC, PICK_TGT, APPLY, CHECK, END);
//   - GAME_PLAYING / GAME_TOP_WIN / GAME_BOT_WIN codes;
//   - ROW_BASE = 5.
//  Sub-module game_cursor holds the row-confined wrap-around position counter.
//   - Inputs: row, load, load_pos, left, right, limit.
//   - Output: object index.
// TESTING
//  1. Reset, num_cfg=3, start.
//     -> total_number=3; digits 0-2 and 5-7 = 1; other digits = 0; cur_player=0; cur_select=0.
//  2. Cursor at 2, right, then cursor at 0, left.
//     -> cursor wraps to 0, then wraps to 2 (cur_select 8); never enters index 3.
//  3. Top player: ok on index 0, cursor to 5 (predict=2), ok.
//     -> digit0=2; cur_player=1; selecting=0; cur_select=20.
//  4. In PICK_TGT, cancel and ok in the same cycle.
//     -> cancel wins; selecting=0; cur_select=selected.
//     -> ok on a zero digit leaves status unchanged.
//  5. Top digits {9,0,0}, bottom digit 1, 9+1 applied.
//     -> digit=0; game_end=1; later buttons are ignored; start re-inits.
//  6. Assert vga_rst during APPLY.
//     -> all outputs 0 immediately; start after release behaves as in test 1.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the two-player digit game controller: state codes,
// result codes, row base and the mod-10 digit adder.
package game_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_PICK_SRC, S_PICK_TGT, S_APPLY, S_CHECK, S_END
  } state_t;

  typedef enum logic [1:0] {
    GAME_PLAYING = 2'd0,
    GAME_TOP_WIN = 2'd1,
    GAME_BOT_WIN = 2'd2
  } game_res_t;

  localparam int          ROW_BASE  = 5;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // 5-bit sum, folded back once: both operands are decimal digits.
  function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 5'd10) ? 4'(s - 5'd10) : s[3:0];
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Button/renderer bundle of the game controller. master = button side, slave = controller.
interface game_ctrl_if
  import game_ctrl_pkg::*;
#(parameter int N_MAX = ROW_BASE);
  logic [2:0]         num_cfg;
  logic               start, btn_left, btn_right, btn_ok, btn_cancel;
  logic [31:0]        total_number;
  logic               cur_player;
  logic [8*N_MAX-1:0] status;
  logic [3:0]         predict;
  logic               selecting;
  logic [31:0]        cur_select, selected;
  logic [1:0]         game_end;

  modport master (
    output num_cfg, start, btn_left, btn_right, btn_ok, btn_cancel,
    input  total_number, cur_player, status, predict, selecting,
           cur_select, selected, game_end
  );
  modport slave (
    input  num_cfg, start, btn_left, btn_right, btn_ok, btn_cancel,
    output total_number, cur_player, status, predict, selecting,
           cur_select, selected, game_end
  );
endinterface

// File: rtl/game_ctrl_cursor.sv
// game_cursor: row-confined cursor; position wraps within 0..limit-1, index = row*N_MAX + pos.
module game_cursor
  import game_ctrl_pkg::*;
#(parameter int N_MAX = ROW_BASE) (
  input  logic       vga_clk,
  input  logic       vga_rst,
  input  logic       row,
  input  logic       load,
  input  logic [2:0] load_pos,
  input  logic       left,
  input  logic       right,
  input  logic [2:0] limit,
  output logic [3:0] idx
);
  logic       row_q;
  logic [2:0] pos_q;

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      row_q <= 1'b0;
      pos_q <= 3'd0;
    end else if (load) begin
      row_q <= row;
      pos_q <= load_pos;
    end else if (left) begin
      pos_q <= (pos_q == 3'd0) ? limit - 3'd1 : pos_q - 3'd1;
    end else if (right) begin
      pos_q <= (pos_q == limit - 3'd1) ? 3'd0 : pos_q + 3'd1;
    end
  end

  assign idx = row_q ? 4'(N_MAX) + {1'b0, pos_q} : {1'b0, pos_q};
endmodule

// File: rtl/game_ctrl.sv
// Turn sequencer for the two-player digit game; owns the board and drives the renderer.
// Define RANDOM_INIT_EN to seed the board from a 16-bit LFSR instead of INIT_DIGIT.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int N_MAX      = ROW_BASE,
  parameter int INIT_DIGIT = 1
) (
  input logic        vga_clk,
  input logic        vga_rst,
  game_ctrl_if.slave gi
);
  state_t                  state;
  logic [2*N_MAX-1:0][3:0] dig;
  logic [2:0]              total;
  logic                    player, sel_on;
  logic [3:0]              pred, sel_idx, cur_idx;
  logic [1:0]              result;

  logic [2:0] num_cl;
  logic       do_cancel, do_ok, do_left, do_right;
  logic [3:0] cur_dig, src_dig;
  logic       mover_zero;
  logic       cur_load, cur_row;
  logic [2:0] cur_pos;
  logic       mv_l, mv_r;
  logic [3:0] init_dig [2*N_MAX];

  // one action per cycle: cancel > ok > left > right
  assign do_cancel = gi.btn_cancel;
  assign do_ok     = gi.btn_ok    & ~gi.btn_cancel;
  assign do_left   = gi.btn_left  & ~gi.btn_ok & ~gi.btn_cancel;
  assign do_right  = gi.btn_right & ~gi.btn_left & ~gi.btn_ok & ~gi.btn_cancel;

  assign cur_dig = dig[cur_idx];
  assign src_dig = dig[sel_idx];
  // unused digits are held at zero, so the whole row can be tested
  assign mover_zero = player ? ~|dig[2*N_MAX-1:N_MAX] : ~|dig[N_MAX-1:0];

  always_comb begin
    num_cl = gi.num_cfg;
    if (gi.num_cfg == 3'd0)            num_cl = 3'd1;
    else if (gi.num_cfg > 3'(N_MAX))   num_cl = 3'(N_MAX);
  end

`ifdef RANDOM_INIT_EN
  logic [15:0] lfsr;
  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  always_comb
    for (int i = 0; i < 2*N_MAX; i++) init_dig[i] = 4'd1 + (lfsr[(i % 13) +: 4] % 4'd9);
`else
  always_comb
    for (int i = 0; i < 2*N_MAX; i++) init_dig[i] = 4'(INIT_DIGIT);
`endif

  always_comb begin
    cur_load = 1'b0;
    cur_row  = 1'b0;
    cur_pos  = 3'd0;
    mv_l     = 1'b0;
    mv_r     = 1'b0;
    case (state)
      S_INIT: cur_load = 1'b1;
      S_PICK_SRC:
        if (do_ok && cur_dig != 4'd0) begin
          cur_load = 1'b1;
          cur_row  = ~player;
        end else begin
          mv_l = do_left;
          mv_r = do_right;
        end
      S_PICK_TGT:
        if (do_cancel) begin
          cur_load = 1'b1;
          cur_row  = (sel_idx >= 4'(N_MAX));
          cur_pos  = cur_row ? 3'(sel_idx - 4'(N_MAX)) : sel_idx[2:0];
        end else if (!do_ok) begin
          mv_l = do_left;
          mv_r = do_right;
        end
      S_CHECK:
        if (!mover_zero) begin
          cur_load = 1'b1;
          cur_row  = ~player;
        end
      default: ;
    endcase
  end

  game_cursor #(.N_MAX(N_MAX)) u_cursor (
    .vga_clk (vga_clk),
    .vga_rst (vga_rst),
    .row     (cur_row),
    .load    (cur_load),
    .load_pos(cur_pos),
    .left    (mv_l),
    .right   (mv_r),
    .limit   (total),
    .idx     (cur_idx)
  );

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      state   <= S_IDLE;
      dig     <= '0;
      total   <= 3'd0;
      player  <= 1'b0;
      sel_on  <= 1'b0;
      sel_idx <= 4'd0;
      pred    <= 4'd0;
      result  <= GAME_PLAYING;
    end else begin
      pred <= sel_on ? add_mod10(src_dig, cur_dig) : 4'd0;
      case (state)
        S_IDLE, S_END:
          if (gi.start) state <= S_INIT;
        S_INIT: begin
          total <= num_cl;
          for (int i = 0; i < 2*N_MAX; i++)
            dig[i] <= ((i % N_MAX) < int'(num_cl)) ? init_dig[i] : 4'd0;
          player <= 1'b0;
          sel_on <= 1'b0;
          result <= GAME_PLAYING;
          state  <= S_PICK_SRC;
        end
        S_PICK_SRC:
          if (do_ok && cur_dig != 4'd0) begin
            sel_idx <= cur_idx;
            sel_on  <= 1'b1;
            state   <= S_PICK_TGT;
          end
        S_PICK_TGT:
          if (do_cancel) begin
            sel_on <= 1'b0;
            state  <= S_PICK_SRC;
          end else if (do_ok && cur_dig != 4'd0) begin
            state <= S_APPLY;
          end
        S_APPLY: begin
          dig[sel_idx] <= add_mod10(src_dig, cur_dig);
          sel_on       <= 1'b0;
          state        <= S_CHECK;
        end
        S_CHECK:
          if (mover_zero) begin
            result <= player ? GAME_BOT_WIN : GAME_TOP_WIN;
            state  <= S_END;
          end else begin
            player <= ~player;
            state  <= S_PICK_SRC;
          end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign gi.total_number = {29'd0, total};
  assign gi.cur_player   = player;
  assign gi.status       = dig;
  assign gi.predict      = pred;
  assign gi.selecting    = sel_on;
  assign gi.cur_select   = {26'd0, cur_idx, 2'b00};
  assign gi.selected     = {26'd0, sel_idx, 2'b00};
  assign gi.game_end     = result;
endmodule
